// File: rtl/apb_req_arbiter_pkg.sv
// Shared types, width defaults and the round-robin selection helper for
// apb_req_arbiter.
package apb_req_arbiter_pkg;

  localparam int unsigned APB_ADDR_WIDTH_DEF = 32;
  localparam int unsigned APB_DATA_WIDTH_DEF = 32;
  localparam int unsigned RR_MAX_REQ         = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } arb_state_e;

  // First set bit of valid, scanning from ptr upward and wrapping at num_req.
  // Returns 0 when nothing is valid; callers qualify with |valid.
  function automatic int unsigned rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                          input int unsigned           ptr,
                                          input int unsigned           num_req);
    int unsigned win;
    int unsigned idx;
    logic        found;
    win   = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
      if (k < num_req) begin
        idx = (ptr + k) % num_req;
        if (!found && (((valid >> idx) & 8'd1) != 8'd0)) begin
          found = 1'b1;
          win   = idx;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/apb_req_arbiter_picker.sv
// Combinational round-robin picker: find the first valid requester starting
// at the rotating pointer.
module apb_rr_picker
  import apb_req_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   winner,
  output logic [NUM_REQ-1:0] onehot
);

  logic [RR_MAX_REQ-1:0] valid_ext;
  int unsigned           win_idx;

  // Widen the request vector to the helper's fixed width and select.
  always_comb begin
    valid_ext              = '0;
    valid_ext[NUM_REQ-1:0] = valid;
    win_idx                = rr_pick(valid_ext, 32'(ptr), NUM_REQ);
    winner                 = IDX_W'(win_idx);
    found                  = |valid;
    onehot                 = '0;
    if (found) begin
      onehot[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master among NUM_REQ requesters.
// Optional macro APB_ARB_LOCK_EN adds req_lock: a locked requester keeps the
// round-robin pointer so it wins again while it stays valid.
module apb_req_arbiter
  import apb_req_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned ADDR_WIDTH = APB_ADDR_WIDTH_DEF,
  parameter  int unsigned DATA_WIDTH = APB_DATA_WIDTH_DEF,
  localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          Pclk,
  input  logic                          Preset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
`ifdef APB_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock,
`endif
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_slverr,
  output logic                          transfer,
  output logic                          WRITE_READ,
  output logic [ADDR_WIDTH-1:0]         APB_write_paddr,
  output logic [ADDR_WIDTH-1:0]         APB_read_paddr,
  output logic [DATA_WIDTH-1:0]         APB_write_data,
  input  logic                          Psel,
  input  logic                          Penable,
  input  logic                          Pready,
  input  logic                          Pslverr,
  input  logic [DATA_WIDTH-1:0]         Prdata,
  output logic [IDX_W-1:0]              grant_id
);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       grant_id_q, grant_id_d;
  logic                   write_q, write_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   slverr_q, slverr_d;

  logic                   pick_found;
  logic [IDX_W-1:0]       pick_winner;
  logic [NUM_REQ-1:0]     pick_onehot;

  apb_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .valid  (req_valid),
    .ptr    (rr_ptr_q),
    .found  (pick_found),
    .winner (pick_winner),
    .onehot (pick_onehot)
  );

  // Next-state, latch updates and the per-state handshake outputs.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    slverr_d   = slverr_q;
    req_ready  = '0;
    rsp_valid  = '0;
    transfer   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          req_ready  = pick_onehot;
          grant_id_d = pick_winner;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_winner == IDX_W'(i)) begin
              write_d = req_write[i];
              addr_d  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
              wdata_d = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          state_d = REQ;
        end
      end
      REQ: begin
        transfer = 1'b1;
        if (Psel && !Penable) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (Psel && Penable && (Pready || Pslverr)) begin
          rdata_d  = write_q ? '0 : Prdata;
          slverr_d = Pslverr;
          state_d  = RESP;
        end
      end
      RESP: begin
        rsp_valid[grant_id_q] = 1'b1;
        if (grant_id_q == IDX_W'(NUM_REQ - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = grant_id_q + IDX_W'(1);
        end
`ifdef APB_ARB_LOCK_EN
        if (req_lock[grant_id_q] && req_valid[grant_id_q]) begin
          rr_ptr_d = grant_id_q;
        end
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers with synchronous reset.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      slverr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      slverr_q   <= slverr_d;
    end
  end

  assign WRITE_READ      = write_q;
  assign APB_write_paddr = addr_q;
  assign APB_read_paddr  = addr_q;
  assign APB_write_data  = wdata_q;
  assign rsp_rdata       = rdata_q;
  assign rsp_slverr      = slverr_q;
  assign grant_id        = grant_id_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: transaction-level reference model,
// behavioural APB master, directed scenarios and randomized requesters.
module tb_apb_req_arbiter;

  localparam int NUM = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic              Pclk = 1'b0;
  logic              Preset = 1'b1;
  logic [NUM-1:0]    req_valid = '0;
  logic [NUM-1:0]    req_write = '0;
  logic [NUM*AW-1:0] req_addr = '0;
  logic [NUM*DW-1:0] req_wdata = '0;
  logic [NUM-1:0]    req_lock = '0;
  logic [NUM-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_slverr, transfer, WRITE_READ;
  logic [AW-1:0]     APB_write_paddr, APB_read_paddr;
  logic [DW-1:0]     APB_write_data;
  logic              Psel = 1'b0, Penable = 1'b0, Pready = 1'b0, Pslverr = 1'b0;
  logic [DW-1:0]     Prdata = '0;
  logic [1:0]        grant_id;

  apb_req_arbiter #(
    .NUM_REQ    (NUM),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .Pclk            (Pclk),
    .Preset          (Preset),
    .req_valid       (req_valid),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
`ifdef APB_ARB_LOCK_EN
    .req_lock        (req_lock),
`endif
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_slverr      (rsp_slverr),
    .transfer        (transfer),
    .WRITE_READ      (WRITE_READ),
    .APB_write_paddr (APB_write_paddr),
    .APB_read_paddr  (APB_read_paddr),
    .APB_write_data  (APB_write_data),
    .Psel            (Psel),
    .Penable         (Penable),
    .Pready          (Pready),
    .Pslverr         (Pslverr),
    .Prdata          (Prdata),
    .grant_id        (grant_id)
  );

  always #5 Pclk = ~Pclk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge Pclk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit            m_busy, m_xfer, m_resp, m_write, m_err;
  int            m_ptr, m_gid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  function automatic int pick(input logic [NUM-1:0] v, input int p);
    for (int k = 0; k < NUM; k++)
      if (v[(p + k) % NUM]) return (p + k) % NUM;
    return -1;
  endfunction

  always @(negedge Pclk) begin
    logic [NUM-1:0] exp_ready;
    logic [NUM-1:0] exp_rsp;
    int w;
    if (cyc >= 1) begin
      exp_ready = '0;
      if (!m_busy) begin
        w = pick(req_valid, m_ptr);
        if (w >= 0) exp_ready[w] = 1'b1;
      end
      exp_rsp = '0;
      if (m_resp) exp_rsp[m_gid] = 1'b1;
      chk("cyc_req_ready", req_ready, exp_ready);
      chk("cyc_rsp_valid", rsp_valid, exp_rsp);
      chk("cyc_rsp_rdata", rsp_rdata, m_rdata);
      chk("cyc_rsp_slverr", rsp_slverr, m_err);
      chk("cyc_transfer", transfer, m_xfer);
      chk("cyc_write_read", WRITE_READ, m_write);
      chk("cyc_write_paddr", APB_write_paddr, m_addr);
      chk("cyc_read_paddr", APB_read_paddr, m_addr);
      chk("cyc_write_data", APB_write_data, m_wdata);
      chk("cyc_grant_id", grant_id, 64'(m_gid));

      // advance the model to what the coming edge must produce
      if (Preset) begin
        m_busy = 0; m_xfer = 0; m_resp = 0; m_ptr = 0; m_gid = 0;
        m_write = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 0;
      end else if (m_resp) begin
        m_resp = 0;
        m_busy = 0;
        m_ptr  = (m_gid + 1) % NUM;
`ifdef APB_ARB_LOCK_EN
        if (req_lock[m_gid] && req_valid[m_gid]) m_ptr = m_gid;
`endif
      end else if (!m_busy) begin
        w = pick(req_valid, m_ptr);
        if (w >= 0) begin
          m_busy  = 1;
          m_xfer  = 1;
          m_gid   = w;
          m_write = req_write[w];
          m_addr  = req_addr[w*AW +: AW];
          m_wdata = req_wdata[w*DW +: DW];
        end
      end else if (m_xfer) begin
        if (Psel && !Penable) m_xfer = 0;
      end else if (Psel && Penable && (Pready || Pslverr)) begin
        m_rdata = m_write ? '0 : Prdata;
        m_err   = Pslverr;
        m_resp  = 1;
      end
    end
  end

  // ---------------- behavioural APB master ----------------
  bit            rand_mode = 0;
  int            cfg_waits = 0;
  bit            cfg_err = 0;
  logic [DW-1:0] cfg_rdata = '0;
  logic          xfer_s = 1'b0;
  logic [NUM-1:0] rdy_s = '0;
  bit            rst_s;
  int            mph = 0;
  int            mw = 0;
  bit            merr;
  logic [DW-1:0] mrd;

  always @(negedge Pclk) begin
    xfer_s <= transfer;
    rdy_s  <= req_ready;
  end

  task automatic drive_access();
    Pready  = (mw == 0);
    Pslverr = (mw == 0) && merr;
    Prdata  = (mw == 0) ? mrd : DW'($urandom);
  endtask

  always @(posedge Pclk) begin
    rst_s = Preset;
    #1;
    if (rst_s) begin
      mph = 0; Psel = 0; Penable = 0; Pready = 0; Pslverr = 0;
    end else begin
      case (mph)
        0: begin
          Penable = 0; Pready = 0; Pslverr = 0; Prdata = DW'($urandom);
          if (xfer_s) begin
            Psel = 1;
            mph  = 1;
            mw   = rand_mode ? int'($urandom_range(0, 3)) : cfg_waits;
            merr = rand_mode ? ($urandom_range(0, 3) == 0) : cfg_err;
            mrd  = rand_mode ? DW'($urandom) : cfg_rdata;
          end else begin
            // stray select pulses while the arbiter is not transferring
            Psel = rand_mode && !m_busy && ($urandom_range(0, 7) == 0);
          end
        end
        1: begin
          Penable = 1;
          mph = 2;
          drive_access();
        end
        default: begin
          if (Pready) begin
            Psel = 0; Penable = 0; Pready = 0; Pslverr = 0;
            mph = 0;
          end else begin
            mw--;
            drive_access();
          end
        end
      endcase
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge Pclk);
    #1;
  endtask

  task automatic wait_rsp(input int c0, output int lat);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge Pclk);
      if (rsp_valid != '0) begin
        lat = cyc - c0;
        break;
      end
    end
    chk("rsp_seen", 64'(rsp_valid != '0), 64'd1);
  endtask

  task automatic wait_grant(output int id);
    id = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge Pclk);
      if (req_ready != '0) begin
        for (int j = 0; j < NUM; j++) if (req_ready[j]) id = j;
        break;
      end
    end
    chk("grant_seen", 64'(req_ready != '0), 64'd1);
  endtask

  task automatic do_txn(input int id, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input int waits,
                        input logic [DW-1:0] rd, input bit err,
                        output int lat, output logic [NUM-1:0] rspv,
                        output logic [DW-1:0] rdat, output logic sev);
    int c0;
    cfg_waits = waits; cfg_rdata = rd; cfg_err = err;
    req_valid = NUM'(1 << id);
    req_write[id] = wr;
    req_addr[id*AW +: AW] = addr;
    req_wdata[id*DW +: DW] = data;
    @(negedge Pclk);
    c0 = cyc;
    chk("acc_ready", req_ready, 64'(1 << id));
    tick();
    req_valid = '0;
    wait_rsp(c0, lat);
    rspv = rsp_valid; rdat = rsp_rdata; sev = rsp_slverr;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, id, c0;
    int got[5];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [NUM-1:0] rspv;
    logic [DW-1:0] rd;
    logic se;

    repeat (2) @(posedge Pclk);
    @(negedge Pclk);
    chk("rst_transfer", transfer, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_write_paddr", APB_write_paddr, 0);
    tick();
    Preset = 0;
    tick();

    // single write, no wait states
    do_txn(0, 1, 32'h10, 32'hA5A5_0001, 0, 32'h1234_5678, 0, lat, rspv, rd, se);
    chk("wr_latency", lat, 4);
    chk("wr_rsp_valid", rspv, 4'b0001);
    chk("wr_rdata", rd, 0);
    chk("wr_slverr", se, 0);

    // read with three wait states
    do_txn(2, 0, 32'h20, 32'h0, 3, 32'hDEAD_BEEF, 0, lat, rspv, rd, se);
    chk("rd_latency", lat, 7);
    chk("rd_rsp_valid", rspv, 4'b0100);
    chk("rd_rdata", rd, 32'hDEAD_BEEF);
    chk("rd_slverr", se, 0);

    // reset while waiting for Pready
    cfg_waits = 5; cfg_err = 0;
    req_valid = 4'b0010;
    for (int k = 0; k < 40; k++) begin
      @(negedge Pclk);
      if (Psel && Penable) break;
    end
    chk("rst_mid_access", 64'(Psel && Penable), 64'd1);
    tick();
    req_valid = '0;
    Preset = 1;
    tick();
    Preset = 0;
    @(negedge Pclk);
    chk("rst_mid_transfer", transfer, 0);
    chk("rst_mid_grant", grant_id, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge Pclk);
      chk("rst_mid_no_rsp", rsp_valid, 0);
    end
    tick();

    // fairness with every requester pending (pointer back at 0 after reset)
    cfg_waits = 0;
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant(id);
      got[g] = id;
      if (g == 0) c0 = cyc;
    end
    tick();
    req_valid = '0;
    wait_rsp(c0, lat);
    tick();
    for (int g = 0; g < 5; g++) chk("fair_order", got[g], exp_order[g]);

    // slave error on requester 1, then requester 2 must be next
    do_txn(1, 1, 32'h30, 32'h55, 1, 32'h0, 1, lat, rspv, rd, se);
    chk("err_latency", lat, 5);
    chk("err_rsp_valid", rspv, 4'b0010);
    chk("err_slverr", se, 1);
    req_valid = 4'b1111;
    wait_grant(id);
    c0 = cyc;
    chk("err_next_grant", id, 2);
    tick();
    req_valid = '0;
    wait_rsp(c0, lat);
    tick();

`ifdef APB_ARB_LOCK_EN
    // locked requester 0 keeps winning, then yields once unlocked
    req_valid = 4'b0011;
    req_lock  = 4'b0001;
    for (int g = 0; g < 4; g++) begin
      wait_grant(id);
      got[g] = id;
      c0 = cyc;
      if (g == 2) begin
        tick();
        req_lock = '0;
      end
    end
    tick();
    req_valid = '0;
    wait_rsp(c0, lat);
    tick();
    chk("lock_g0", got[0], 0);
    chk("lock_g1", got[1], 0);
    chk("lock_g2", got[2], 0);
    chk("lock_g3", got[3], 1);
`endif

    // randomized requesters, bus timing and occasional resets
    rand_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      Preset = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < NUM; i++) begin
        if (req_valid[i] && rdy_s[i]) begin
          req_valid[i] = $urandom_range(0, 1);
          req_write[i] = $urandom_range(0, 1);
          req_addr[i*AW +: AW]  = AW'($urandom);
          req_wdata[i*DW +: DW] = DW'($urandom);
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_write[i] = $urandom_range(0, 1);
          req_addr[i*AW +: AW]  = AW'($urandom);
          req_wdata[i*DW +: DW] = DW'($urandom);
        end
      end
`ifdef APB_ARB_LOCK_EN
      req_lock = NUM'($urandom);
`endif
      tick();
    end
    Preset = 0;
    req_valid = '0;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
